// File: rtl/dh_game_pkg.sv
// Shared types and default tuning constants for the Duck Hunt game-flow sequencer.
package dh_game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      FLY,
      FALL,
      ESCAPE,
      PAUSE,
      ROUND_END,
      GAME_OVER
   } game_state_t;

   localparam int AMMO_PER_DUCK_DEF   = 3;
   localparam int DUCKS_PER_ROUND_DEF = 10;
   localparam int MIN_HITS_DEF        = 6;
   localparam int FLIGHT_FRAMES_DEF   = 300;
   localparam int PAUSE_FRAMES_DEF    = 60;
   localparam int ROUND_MAX           = 9;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter (00..99) that saturates at 99; clear wins over increment.
module bcd2_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       inc_i,
   output logic [3:0] ones_o,
   output logic [3:0] tens_o
);

   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      ones_d = ones_q;
      tens_d = tens_q;
      if (clear_i) begin
         ones_d = '0;
         tens_d = '0;
      end else if (inc_i && !(ones_q == 4'd9 && tens_q == 4'd9)) begin
         if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ones_q <= '0;
         tens_q <= '0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end

   assign ones_o = ones_q;
   assign tens_o = tens_q;

endmodule

// File: rtl/ctl_game.sv
// Duck Hunt game-flow sequencer: duck life cycle, ammo/score/round bookkeeping and
// spawn/kill/escape commands to the duck controller. All outputs are registered.
module ctl_game
   import dh_game_pkg::*;
#(
   parameter int AMMO_PER_DUCK   = AMMO_PER_DUCK_DEF,
   parameter int DUCKS_PER_ROUND = DUCKS_PER_ROUND_DEF,
   parameter int MIN_HITS        = MIN_HITS_DEF,
   parameter int FLIGHT_FRAMES   = FLIGHT_FRAMES_DEF,
   parameter int PAUSE_FRAMES    = PAUSE_FRAMES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_frame,
   input  logic       start,
   input  logic       hit,
   input  logic       miss,
   input  logic       duck_offscreen,
   output logic       duck_spawn,
   output logic       duck_kill,
   output logic       duck_escape,
   output logic [3:0] ammo,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [3:0] duck_idx,
   output logic [3:0] round_num,
   output logic       game_over
);

   localparam int TIMER_W = $clog2(max2(FLIGHT_FRAMES, PAUSE_FRAMES));

   localparam logic [TIMER_W-1:0] FLY_LAST   = TIMER_W'(FLIGHT_FRAMES - 1);
   localparam logic [TIMER_W-1:0] PAUSE_LAST = TIMER_W'(PAUSE_FRAMES - 1);
   localparam logic [3:0]         AMMO_INIT  = 4'(AMMO_PER_DUCK);
   localparam logic [3:0]         IDX_LAST   = 4'(DUCKS_PER_ROUND - 1);
   localparam logic [3:0]         HITS_MIN   = 4'(MIN_HITS);
   localparam logic [3:0]         ROUND_TOP  = 4'(ROUND_MAX);

   game_state_t        state_q;
   logic [3:0]         ammo_q;
   logic [TIMER_W-1:0] timer_q;
   logic [3:0]         hits_q;
   logic [3:0]         idx_q;
   logic [3:0]         round_q;
   logic               spawn_q;
   logic               kill_q;
   logic               escape_q;
   logic               over_q;

   logic               game_start;
   logic               score_inc;

   assign game_start = start && (state_q == IDLE || state_q == GAME_OVER);
   assign score_inc  = hit && (state_q == FLY);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         ammo_q   <= '0;
         timer_q  <= '0;
         hits_q   <= '0;
         idx_q    <= '0;
         round_q  <= 4'd1;
         spawn_q  <= 1'b0;
         kill_q   <= 1'b0;
         escape_q <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         spawn_q  <= 1'b0;
         kill_q   <= 1'b0;
         escape_q <= 1'b0;
         case (state_q)
            IDLE, GAME_OVER: begin
               if (game_start) begin
                  round_q <= 4'd1;
                  idx_q   <= '0;
                  hits_q  <= '0;
                  over_q  <= 1'b0;
                  spawn_q <= 1'b1;
                  state_q <= SPAWN;
               end
            end
            SPAWN: begin
               ammo_q  <= AMMO_INIT;
               timer_q <= '0;
               state_q <= FLY;
            end
            FLY: begin
               // A shot always beats a coincident flight timeout.
               if (hit) begin
                  ammo_q  <= ammo_q - 4'd1;
                  hits_q  <= hits_q + 4'd1;
                  kill_q  <= 1'b1;
                  state_q <= FALL;
               end else if (miss) begin
                  ammo_q <= ammo_q - 4'd1;
                  if (ammo_q == 4'd1) begin
                     escape_q <= 1'b1;
                     state_q  <= ESCAPE;
                  end
               end else if (new_frame) begin
                  if (timer_q == FLY_LAST) begin
                     escape_q <= 1'b1;
                     state_q  <= ESCAPE;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end
            FALL, ESCAPE: begin
               if (duck_offscreen) begin
                  timer_q <= '0;
                  state_q <= PAUSE;
               end
            end
            PAUSE: begin
               if (new_frame) begin
                  if (timer_q == PAUSE_LAST) begin
                     timer_q <= '0;
                     if (idx_q == IDX_LAST) begin
                        state_q <= ROUND_END;
                     end else begin
                        idx_q   <= idx_q + 4'd1;
                        spawn_q <= 1'b1;
                        state_q <= SPAWN;
                     end
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end
            ROUND_END: begin
               if (hits_q >= HITS_MIN) begin
                  if (round_q != ROUND_TOP) round_q <= round_q + 4'd1;
                  hits_q  <= '0;
                  idx_q   <= '0;
                  spawn_q <= 1'b1;
                  state_q <= SPAWN;
               end else begin
                  over_q  <= 1'b1;
                  state_q <= GAME_OVER;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bcd2_counter u_score (
      .clk    (clk),
      .rst_n  (rst),
      .clear_i(game_start),
      .inc_i  (score_inc),
      .ones_o (score_ones),
      .tens_o (score_tens)
   );

   assign duck_spawn  = spawn_q;
   assign duck_kill   = kill_q;
   assign duck_escape = escape_q;
   assign ammo        = ammo_q;
   assign duck_idx    = idx_q;
   assign round_num   = round_q;
   assign game_over   = over_q;

endmodule

// File: tb/tb_ctl_game.sv
// Randomized self-checking bench for ctl_game; expectations come from a duck-level
// model (score/round/ammo arithmetic per duck episode) kept in the bench.
module tb_ctl_game;

   localparam int AMMO   = 3;
   localparam int DUCKS  = 3;
   localparam int MINH   = 2;
   localparam int FLIGHT = 5;
   localparam int PAUSE  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic new_frame = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0, duck_offscreen = 1'b0;
   logic duck_spawn, duck_kill, duck_escape, game_over;
   logic [3:0] ammo, score_ones, score_tens, duck_idx, round_num;

   int n_checks = 0;
   int n_pass   = 0;

   int exp_score = 0, exp_round = 1, exp_idx = 0, exp_hits = 0, exp_ammo = 0;
   bit exp_over = 1'b0;
   int exp_spawns = 0, exp_kills = 0, exp_escapes = 0;
   int spawn_cnt = 0, kill_cnt = 0, esc_cnt = 0;
   int fly_frames = 0;

   ctl_game #(
      .AMMO_PER_DUCK  (AMMO),
      .DUCKS_PER_ROUND(DUCKS),
      .MIN_HITS       (MINH),
      .FLIGHT_FRAMES  (FLIGHT),
      .PAUSE_FRAMES   (PAUSE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .new_frame     (new_frame),
      .start         (start),
      .hit           (hit),
      .miss          (miss),
      .duck_offscreen(duck_offscreen),
      .duck_spawn    (duck_spawn),
      .duck_kill     (duck_kill),
      .duck_escape   (duck_escape),
      .ammo          (ammo),
      .score_ones    (score_ones),
      .score_tens    (score_tens),
      .duck_idx      (duck_idx),
      .round_num     (round_num),
      .game_over     (game_over)
   );

   always #5 clk = ~clk;

   // Pulse tally: a pulse stretched past one cycle inflates these counts.
   always @(negedge clk) begin
      if (duck_spawn === 1'b1)  spawn_cnt++;
      if (duck_kill === 1'b1)   kill_cnt++;
      if (duck_escape === 1'b1) esc_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_score(input string tag);
      check({tag, "_ones"}, score_ones, exp_score % 10);
      check({tag, "_tens"}, score_tens, exp_score / 10);
   endtask

   task automatic check_counts();
      @(negedge clk);
      #1;
      check("spawn_count", spawn_cnt, exp_spawns);
      check("kill_count", kill_cnt, exp_kills);
      check("escape_count", esc_cnt, exp_escapes);
   endtask

   // Idle cycles in flight; frames only while they cannot cause a timeout.
   task automatic fly_gap();
      int n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         new_frame = (fly_frames < FLIGHT - 1) && ($urandom_range(0, 1) == 1);
         if (new_frame) fly_frames++;
         step();
         new_frame = 1'b0;
      end
   endtask

   task automatic do_miss();
      miss = 1'b1;
      step();
      miss = 1'b0;
      exp_ammo--;
      check("ammo_after_miss", ammo, exp_ammo);
      if (exp_ammo == 0) begin
         check("escape_on_last_miss", duck_escape, 1);
         exp_escapes++;
      end else begin
         check("no_escape_on_miss", duck_escape, 0);
      end
   endtask

   task automatic do_hit(input bit with_miss, input bit with_frame);
      hit = 1'b1;
      miss = with_miss;
      new_frame = with_frame;
      step();
      hit = 1'b0;
      miss = 1'b0;
      new_frame = 1'b0;
      exp_ammo--;
      exp_hits++;
      if (exp_score < 99) exp_score++;
      exp_kills++;
      check("kill_on_hit", duck_kill, 1);
      check("no_escape_on_hit", duck_escape, 0);
      check("ammo_after_hit", ammo, exp_ammo);
      check_score("score_after_hit");
   endtask

   // One duck: spawn check, flight episode, stray inputs, offscreen, pause, round decision.
   // kind 0: misses then hit; 1: three misses; 2: flight timeout; 3: hit on the timeout frame.
   task automatic run_duck(input int kind, input int nmiss, input bit both);
      check("spawn_pulse", duck_spawn, 1);
      exp_spawns++;
      check("duck_idx", duck_idx, exp_idx);
      check("round_num", round_num, exp_round);
      check("game_over_low", game_over, 0);
      check_score("score_at_spawn");
      step();
      check("spawn_one_cycle", duck_spawn, 0);
      exp_ammo = AMMO;
      check("ammo_init", ammo, exp_ammo);
      fly_frames = 0;

      case (kind)
         0: begin
            for (int i = 0; i < nmiss; i++) begin
               fly_gap();
               do_miss();
            end
            fly_gap();
            do_hit(both, 1'b0);
         end
         1: begin
            for (int i = 0; i < AMMO; i++) begin
               fly_gap();
               do_miss();
            end
         end
         2: begin
            for (int i = 0; i < nmiss; i++) begin
               fly_gap();
               do_miss();
            end
            while (fly_frames < FLIGHT) begin
               new_frame = 1'b1;
               step();
               new_frame = 1'b0;
               fly_frames++;
               if (fly_frames == FLIGHT) begin
                  check("escape_on_timeout", duck_escape, 1);
                  exp_escapes++;
               end else begin
                  check("no_early_timeout", duck_escape, 0);
               end
            end
            check("ammo_after_timeout", ammo, exp_ammo);
         end
         default: begin
            while (fly_frames < FLIGHT - 1) begin
               new_frame = 1'b1;
               step();
               new_frame = 1'b0;
               fly_frames++;
            end
            do_hit(1'b0, 1'b1);
         end
      endcase

      // Stray shots, frames and start while falling/escaping change nothing.
      begin
         int n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            hit = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            miss = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            new_frame = 1'($urandom_range(0, 1));
            step();
            {hit, miss, start, new_frame} = '0;
            check("stray_ammo", ammo, exp_ammo);
            check_score("stray_score");
            check("stray_no_spawn", duck_spawn, 0);
            check("stray_no_kill", duck_kill, 0);
         end
      end

      duck_offscreen = 1'b1;
      step();
      duck_offscreen = 1'b0;

      for (int p = 0; p < PAUSE; p++) begin
         int g = $urandom_range(0, 2);
         for (int i = 0; i < g; i++) begin
            hit = 1'($urandom_range(0, 1));
            step();
            hit = 1'b0;
         end
         new_frame = 1'b1;
         step();
         new_frame = 1'b0;
         if (p < PAUSE - 1) check("pause_no_spawn", duck_spawn, 0);
      end

      if (exp_idx < DUCKS - 1) begin
         exp_idx++;
      end else begin
         check("round_end_no_spawn", duck_spawn, 0);
         step();
         if (exp_hits >= MINH) begin
            if (exp_round < 9) exp_round++;
            exp_hits = 0;
            exp_idx  = 0;
         end else begin
            exp_over = 1'b1;
            check("game_over_set", game_over, 1);
            check("game_over_no_spawn", duck_spawn, 0);
            check("game_over_round_held", round_num, exp_round);
            check_score("game_over_score_held");
         end
      end
   endtask

   task automatic restart();
      exp_score = 0;
      exp_round = 1;
      exp_idx   = 0;
      exp_hits  = 0;
      exp_over  = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) step();
      check("rst_ammo", ammo, 0);
      check_score("rst_score");
      check("rst_idx", duck_idx, 0);
      check("rst_round", round_num, 1);
      check("rst_game_over", game_over, 0);
      check("rst_spawn", duck_spawn, 0);
      check("rst_kill", duck_kill, 0);
      check("rst_escape", duck_escape, 0);
      rst = 1'b1;
      step();
      check("idle_no_spawn", duck_spawn, 0);

      // Round 1: escape by misses, hit+miss together, timeout -> one hit -> game over.
      restart();
      run_duck(1, 0, 1'b0);
      run_duck(0, 0, 1'b1);
      run_duck(2, 0, 1'b0);
      check("directed_game_over", exp_over, 1);
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("over_hit_ignored_go", game_over, 1);
      check_score("over_hit_ignored");

      // Fresh game: two hits in three ducks advances to round 2.
      restart();
      run_duck(0, 1, 1'b0);
      run_duck(0, 2, 1'b0);
      run_duck(1, 0, 1'b0);

      for (int d = 0; d < 40; d++) begin
         if (exp_over) restart();
         run_duck($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      if (exp_over) restart();

      // Every duck hit: walks the score through 09->10 and up to saturation at 99.
      while (exp_hits + exp_score < 102 && !(exp_score == 99 && exp_hits >= 1 && exp_idx == 1)) begin
         if ($urandom_range(0, 1) == 1) run_duck(0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         else run_duck(3, 0, 1'b0);
      end
      check("round_saturated", exp_round, 9);

      // Reset in flight with a coincident hit.
      check("pre_reset_spawn", duck_spawn, 1);
      exp_spawns++;
      step();
      check("pre_reset_ammo", ammo, AMMO);
      rst = 1'b0;
      hit = 1'b1;
      step();
      hit = 1'b0;
      rst = 1'b1;
      check("midrst_ammo", ammo, 0);
      exp_score = 0;
      check_score("midrst_score");
      check("midrst_idx", duck_idx, 0);
      check("midrst_round", round_num, 1);
      check("midrst_game_over", game_over, 0);
      check("midrst_kill", duck_kill, 0);
      check("midrst_spawn", duck_spawn, 0);
      check("midrst_escape", duck_escape, 0);
      step();
      check("post_rst_idle", duck_spawn, 0);
      check_counts();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ctl_game.md
Name: ctl_game

Overview:
- Game-flow sequencer for Duck Hunt; sits between the shot-resolution logic (hit/miss pulses) and the duck motion controller and score display.
- Schedules each duck's life cycle: spawn, flight, fall or escape, inter-duck pause.
- Owns the ammo, score, duck-index and round counters; decides round advance or game over.
- Drives the hex display digits and the start/kill/escape commands to the duck controller.

Parameters:
- AMMO_PER_DUCK, 3, shots granted per duck.
- DUCKS_PER_ROUND, 10, ducks per round.
- MIN_HITS, 6, hits needed in a round to advance.
- FLIGHT_FRAMES, 300, frames before an unhit duck flies away.
- PAUSE_FRAMES, 60, frames between ducks.

Ports:
- clk  in  1  main 65 MHz clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- new_frame  in  1  one-cycle pulse per VGA frame.
- start  in  1  one-cycle pulse; starts or restarts the game.
- hit  in  1  one-cycle pulse; a shot hit the duck.
- miss  in  1  one-cycle pulse; a shot missed.
- duck_offscreen  in  1  level from the duck controller; duck is outside the play area.
- duck_spawn  out  1  one-cycle pulse; launch a new duck.
- duck_kill  out  1  one-cycle pulse; the duck was shot and starts falling.
- duck_escape  out  1  one-cycle pulse; the duck flies away.
- ammo  out  4  remaining shots, binary 0..AMMO_PER_DUCK.
- score_ones  out  4  BCD score units digit.
- score_tens  out  4  BCD score tens digit.
- duck_idx  out  4  index of the current duck in the round, 0..DUCKS_PER_ROUND-1.
- round_num  out  4  current round, 1..9.
- game_over  out  1  level; high while in GAME_OVER.

Behaviour:
- Reset (rst=0, sampled on clk):
  - state=IDLE.
  - All outputs 0, except round_num=1.
  - Internal timers and round_hits=0.
- All outputs are registered. A pulse output goes high in the cycle after the input event that causes it, and stays high for exactly one cycle.
- IDLE:
  - On start: clear score, set round_num=1, duck_idx=0, round_hits=0, then go to SPAWN.
- SPAWN (one cycle):
  - Set ammo=AMMO_PER_DUCK, clear frame_timer, assert duck_spawn, go to FLY.
- FLY:
  - hit:
    - ammo-=1, round_hits+=1.
    - Score increments as 2-digit BCD; 09 rolls to 10; saturates at 99.
    - Assert duck_kill, go to FALL.
  - miss:
    - ammo-=1.
    - If ammo was 1: assert duck_escape, go to ESCAPE.
  - hit and miss in the same cycle: treat as hit only; ammo decrements by 1 once.
  - new_frame: frame_timer+=1. When frame_timer reaches FLIGHT_FRAMES-1 on a new_frame, assert duck_escape and go to ESCAPE.
  - A hit/miss in the same cycle as the timeout new_frame: the shot takes priority, and the timeout is discarded.
- FALL, ESCAPE:
  - hit and miss are ignored; ammo is unchanged.
  - When duck_offscreen=1: clear frame_timer, go to PAUSE.
- PAUSE:
  - Count PAUSE_FRAMES new_frame pulses.
  - If duck_idx==DUCKS_PER_ROUND-1, go to ROUND_END.
  - Otherwise duck_idx+=1 and go to SPAWN.
- ROUND_END (one cycle):
  - If round_hits>=MIN_HITS: round_num+=1 (saturate at 9), round_hits=0, duck_idx=0, go to SPAWN.
  - Otherwise go to GAME_OVER.
- GAME_OVER:
  - game_over=1; score and round_num are held.
  - On start: same action as start in IDLE.
- start in any state other than IDLE or GAME_OVER is ignored.
- Reset mid-game overrides everything, including pending pulses; no pulse output is asserted in the cycle after reset.
- Counter widths: ammo 4 b, frame_timer sized by $clog2 of max(FLIGHT_FRAMES, PAUSE_FRAMES), round_hits 4 b.

Decomposition:
- Package dh_game_pkg holds:
  - game_state_t enum: IDLE, SPAWN, FLY, FALL, ESCAPE, PAUSE, ROUND_END, GAME_OVER.
  - The default parameter constants.
- One sub-module, bcd2_counter: 2-digit saturating BCD counter with clear and inc inputs and an active-low synchronous reset. It produces score_ones and score_tens.

Test Plan (sim params FLIGHT_FRAMES=5, PAUSE_FRAMES=2, DUCKS_PER_ROUND=3, MIN_HITS=2):
- Reset held low 3 cycles, then start → duck_spawn high exactly one cycle after start; ammo=3 one cycle after that; score=00, round_num=1.
- During FLY: miss, miss, miss → ammo goes 2, 1, 0; duck_escape one cycle after the third miss; a later hit in ESCAPE leaves the score at 00.
- hit and miss in the same cycle during FLY → ammo=2, score=01, a single duck_kill pulse; then duck_offscreen=1 plus 2 new_frames → duck_spawn with duck_idx=1.
- No shots, 5 new_frames in FLY → duck_escape after the 5th new_frame; score unchanged.
- Round of 3 ducks with 2 hits → round_num=2, duck_idx=0, spawn. Round with 1 hit → game_over=1; start → score=00, round_num=1, duck_spawn.
- Preload score to 99, then hit → score stays 99. Score 09 plus hit → score 10. Reset asserted in FLY → all outputs at reset values, with round_num=1, in the next cycle.
